// File: rtl/game_screen_drawer.sv
// game_screen_drawer
// Paints the memory game's current picture into a 1-bit VGA frame buffer,
// one pixel per clock. Every new picture is an erase of the whole frame in
// raster order (x fastest) followed by a fill of the selected region.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   display[2:0] picture code: 0 blank, 1-4 box for number 0-3, 5 full
//                screen, 6-7 blank
//   clear        one-cycle request to repaint the current code
//   x, y         pixel coordinate of the write
//   pixel_color  write data (0 off, 1 on)
//   write        frame-buffer write enable
//   busy         high while a sweep is in progress
//   done         one-cycle pulse after the final write of a request
//
// Optional feature: define GAME_SCREEN_OUTLINE_EN to draw only the box
// perimeter. The sweep still visits every box pixel, so timing is unchanged.
module game_screen_drawer #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned BOX_H    = 120,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    display,
  input  logic          clear,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          pixel_color,
  output logic          write,
  output logic          busy,
  output logic          done
);

  localparam int unsigned QW = SCREEN_W / 4;
  localparam logic [XW-1:0] XMAX   = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] YMAX   = YW'(SCREEN_H - 1);
  localparam logic [YW-1:0] BOX_Y0 = YW'((SCREEN_H - BOX_H) / 2);
  localparam logic [YW-1:0] BOX_Y1 = YW'((SCREEN_H + BOX_H) / 2 - 1);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    drawn_q, drawn_d;
  logic [2:0]    cur_q, cur_d;            // code being painted by this sweep
  logic [2:0]    pend_code_q, pend_code_d;
  logic          pend_q, pend_d;
  logic          pend_clr_q, pend_clr_d;  // a waiting request includes a clear
  logic          force_q, force_d;        // frame contents unknown after reset

  logic          req;
  logic          has_box;
  logic [XW-1:0] bx0, bx1;
  logic [YW-1:0] by0, by1;

  // Region bounds for the code being painted; all constants at elaboration.
  always_comb begin
    has_box = 1'b1;
    bx0     = '0;
    bx1     = XMAX;
    by0     = BOX_Y0;
    by1     = BOX_Y1;
    case (cur_q)
      3'd1: bx1 = XW'(QW - 1);
      3'd2: begin bx0 = XW'(QW);     bx1 = XW'(2 * QW - 1); end
      3'd3: begin bx0 = XW'(2 * QW); bx1 = XW'(3 * QW - 1); end
      3'd4: begin bx0 = XW'(3 * QW); bx1 = XMAX;            end
      3'd5: begin by0 = '0;          by1 = YMAX;            end
      default: has_box = 1'b0;
    endcase
  end

  assign req = (display != drawn_q) || clear;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    drawn_d     = drawn_q;
    cur_d       = cur_q;
    pend_code_d = pend_code_q;
    pend_d      = pend_q;
    pend_clr_d  = pend_clr_q;
    force_d     = force_q;
    write       = 1'b0;
    pixel_color = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    // Requests arriving mid-sweep are queued; the latest code wins.
    if (state_q != StIdle && req) begin
      pend_d      = 1'b1;
      pend_code_d = display;
      pend_clr_d  = pend_clr_q | clear;
    end

    unique case (state_q)
      StIdle: begin
        if (force_q || req) begin
          force_d = 1'b0;
          cur_d   = force_q ? 3'd0 : display;
          x_d     = '0;
          y_d     = '0;
          state_d = StErase;
        end
      end
      StErase: begin
        write = 1'b1;
        busy  = 1'b1;
        if (x_q == XMAX) begin
          if (y_q == YMAX) begin
            if (has_box) begin
              x_d     = bx0;
              y_d     = by0;
              state_d = StDraw;
            end else begin
              state_d = StDone;
            end
          end else begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      StDraw: begin
        busy        = 1'b1;
        pixel_color = 1'b1;
`ifdef GAME_SCREEN_OUTLINE_EN
        write = (x_q == bx0) || (x_q == bx1) || (y_q == by0) || (y_q == by1);
`else
        write = 1'b1;
`endif
        if (x_q == bx1) begin
          if (y_q == by1) begin
            state_d = StDone;
          end else begin
            x_d = bx0;
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        drawn_d = cur_q;
        if (pend_d && ((pend_code_d != cur_q) || pend_clr_d)) begin
          cur_d   = pend_code_d;
          x_d     = '0;
          y_d     = '0;
          state_d = StErase;
        end else begin
          state_d = StIdle;
        end
        pend_d     = 1'b0;
        pend_clr_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      drawn_q     <= 3'd0;
      cur_q       <= 3'd0;
      pend_code_q <= 3'd0;
      pend_q      <= 1'b0;
      pend_clr_q  <= 1'b0;
      force_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      drawn_q     <= drawn_d;
      cur_q       <= cur_d;
      pend_code_q <= pend_code_d;
      pend_q      <= pend_d;
      pend_clr_q  <= pend_clr_d;
      force_q     <= force_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: tb/tb_game_screen_drawer.sv
// Self-checking bench for game_screen_drawer on an 8x4 frame with a 2-row box.
// A cycle-level reference model turns each accepted request into a timed list
// of expected writes plus a done pulse; a monitor on the falling edge matches
// the DUT's writes/done pulses against that list, including the cycle stamp.
module tb_game_screen_drawer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int BH = 2;
`ifdef GAME_SCREEN_OUTLINE_EN
  localparam bit OUTLINE = 1'b1;
`else
  localparam bit OUTLINE = 1'b0;
`endif

  bit         clk;
  logic       reset;
  logic [2:0] display;
  logic       clear;
  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_color, write, busy, done;

  game_screen_drawer #(
    .SCREEN_W(W), .SCREEN_H(H), .BOX_H(BH), .XW(10), .YW(9)
  ) dut (
    .clk(clk), .reset(reset), .display(display), .clear(clear),
    .x(x), .y(y), .pixel_color(pixel_color), .write(write),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit dn;
    int px;
    int py;
    bit c;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  passes = 0;

  // Reference model state
  int  cyc = 0;
  bit  m_busy = 0;
  bit  m_force = 0;
  bit  rst_chk = 0;
  int  m_drawn = 0, m_cur = 0, m_pcode = 0, m_done_cyc = 0;
  bit  m_pend = 0, m_pclr = 0;

  task automatic chk(input bit ok, input string nm, input string act, input string exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %s, expected %s", nm, act, exp);
  endtask

  // Expected event list for one request sampled at edge e; returns done stamp.
  function automatic int push_sweep(int e, int code);
    int k = 0;
    int x0, x1, y0, y1;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        q.push_back('{cyc: e + k, dn: 1'b0, px: xx, py: yy, c: 1'b0});
        k++;
      end
    if (code >= 1 && code <= 5) begin
      if (code == 5) begin
        x0 = 0; x1 = W - 1; y0 = 0; y1 = H - 1;
      end else begin
        x0 = (code - 1) * (W / 4);
        x1 = code * (W / 4) - 1;
        y0 = (H - BH) / 2;
        y1 = (H + BH) / 2 - 1;
      end
      for (int yy = y0; yy <= y1; yy++)
        for (int xx = x0; xx <= x1; xx++) begin
          if (!OUTLINE || xx == x0 || xx == x1 || yy == y0 || yy == y1)
            q.push_back('{cyc: e + k, dn: 1'b0, px: xx, py: yy, c: 1'b1});
          k++;
        end
    end
    q.push_back('{cyc: e + k, dn: 1'b1, px: 0, py: 0, c: 1'b0});
    return e + k;
  endfunction

  task automatic m_start(input int code);
    m_cur      = code;
    m_busy     = 1;
    m_done_cyc = push_sweep(cyc, code);
  endtask

  always @(posedge clk) begin
    bit r;
    cyc++;
    if (reset) begin
      q.delete();
      m_busy = 0; m_drawn = 0; m_pend = 0; m_pclr = 0; m_force = 1;
      rst_chk = 1;
    end else begin
      rst_chk = 0;
      r = (int'(display) != m_drawn) || clear;
      if (!m_busy) begin
        if (m_force) begin
          m_force = 0;
          m_start(0);
        end else if (r) begin
          m_start(int'(display));
        end
      end else begin
        if (r) begin
          m_pend = 1; m_pcode = int'(display); m_pclr = m_pclr | clear;
        end
        if (cyc == m_done_cyc + 1) begin
          m_drawn = m_cur;
          if (m_pend && (m_pcode != m_drawn || m_pclr)) m_start(m_pcode);
          else m_busy = 0;
          m_pend = 0; m_pclr = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst_chk) begin
      chk(!write && !busy && !done && !pixel_color && x == 0 && y == 0, "reset_outputs",
          $sformatf("w=%0b b=%0b d=%0b c=%0b x=%0d y=%0d", write, busy, done, pixel_color, x, y),
          "all zero");
    end else if (write || done) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_event", $sformatf("cyc=%0d w=%0b d=%0b x=%0d y=%0d",
            cyc, write, done, x, y), "no activity");
      end else begin
        e = q.pop_front();
        if (e.dn)
          chk(done && !write && !busy && cyc == e.cyc, "done_pulse",
              $sformatf("cyc=%0d d=%0b w=%0b b=%0b", cyc, done, write, busy),
              $sformatf("cyc=%0d d=1 w=0 b=0", e.cyc));
        else
          chk(write && !done && busy && cyc == e.cyc && int'(x) == e.px && int'(y) == e.py
              && pixel_color == e.c, "pixel_write",
              $sformatf("cyc=%0d d=%0b b=%0b (%0d,%0d) c=%0b", cyc, done, busy, x, y,
                        pixel_color),
              $sformatf("cyc=%0d d=0 b=1 (%0d,%0d) c=%0b", e.cyc, e.px, e.py, e.c));
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk(1'b0, e.dn ? "missing_done" : "missing_write", $sformatf("cyc=%0d nothing", cyc),
          $sformatf("cyc=%0d (%0d,%0d) c=%0b", e.cyc, e.px, e.py, e.c));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    step(2);
    while ((m_busy || m_force || q.size() != 0) && n < 2000) begin
      step(1);
      n++;
    end
    if (n >= 2000) chk(1'b0, {"timeout_", nm}, "still busy", "idle within 2000 cycles");
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; display = 3'd0; clear = 1'b0;
    step(3);
    reset = 1'b0;
    wait_idle("reset_erase");

    display = 3'd3;
    wait_idle("box3");

    display = 3'd5;
    wait_idle("full");
    pulse_clear();
    wait_idle("clear_full");

    display = 3'd1;
    step(5);
    display = 3'd2;
    step(5);
    display = 3'd4;
    wait_idle("mid_sweep");

    display = 3'd3;
    step(35);
    reset = 1'b1; display = 3'd0;
    step(1);
    reset = 1'b0;
    wait_idle("reset_mid_draw");

    for (int i = 0; i < 250; i++) begin
      int act;
      step($urandom_range(40, 0));
      act = $urandom_range(99, 0);
      if (act < 70) begin
        display = 3'($urandom_range(7, 0));
      end else if (act < 93) begin
        pulse_clear();
      end else begin
        reset = 1'b1;
        step($urandom_range(2, 1));
        reset = 1'b0;
      end
    end
    wait_idle("random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
